// File: rtl/usb_packet_builder_pkg.sv
// Shared definitions for the USB packet builder and its CRC helpers.
// Contents:
//   - PID constants and PID-class decode functions
//   - FSM state type
//   - CRC5 over the 11-bit token field, returned in transmit bit order
//   - CRC16 byte step (8 serial iterations, LSB first)
//   - Bit-reverse helper used to place CRC16 bytes in transmit order
package usb_packet_builder_pkg;

  localparam logic [3:0] PidOut   = 4'b0001;
  localparam logic [3:0] PidIn    = 4'b1001;
  localparam logic [3:0] PidSof   = 4'b0101;
  localparam logic [3:0] PidSetup = 4'b1101;
  localparam logic [3:0] PidData0 = 4'b0011;
  localparam logic [3:0] PidData1 = 4'b1011;
  localparam logic [3:0] PidData2 = 4'b0111;
  localparam logic [3:0] PidMdata = 4'b1111;

  typedef enum logic [2:0] {
    StIdle,
    StPid,
    StTok1,
    StTok2,
    StData,
    StCrcLo,
    StCrcHi
  } state_e;

  function automatic logic is_token(input logic [3:0] pid);
    return (pid == PidOut) || (pid == PidIn) || (pid == PidSof) || (pid == PidSetup);
  endfunction

  // All data PIDs share the low two bits 2'b11.
  function automatic logic is_data(input logic [3:0] pid);
    return pid[1:0] == 2'b11;
  endfunction

  // Returns the inverted CRC5 already ordered for byte2[7:3]: bit 0 of the
  // result (byte2 bit 3, first on the wire) is ~c[4], bit 4 is ~c[0].
  function automatic logic [4:0] crc5_field(input logic [10:0] d);
    logic [4:0] c;
    logic [4:0] f;
    logic       fb;
    c = 5'h1F;
    for (int i = 0; i < 11; i++) begin
      fb = c[4] ^ d[i];
      c  = {c[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
    end
    for (int i = 0; i < 5; i++) begin
      f[i] = ~c[4-i];
    end
    return f;
  endfunction

  function automatic logic [15:0] crc16_byte_step(input logic [15:0] crc, input logic [7:0] d);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
    end
    return c;
  endfunction

  function automatic logic [7:0] rev8(input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = x[7-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/usb_crc16_byte.sv
// Registered USB CRC16 accumulator, one byte per update strobe.
// Ports:
//   clk_i   clock
//   rst_i   asynchronous active-high reset (preset to 16'hFFFF)
//   clr_i   restart the CRC for a new packet
//   upd_i   fold data_i into the CRC this cycle
//   data_i  payload byte, processed LSB first
//   crc_o   current (non-inverted) CRC register
module usb_crc16_byte
  import usb_packet_builder_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        upd_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      crc_q <= 16'hFFFF;
    end else if (clr_i) begin
      crc_q <= 16'hFFFF;
    end else if (upd_i) begin
      crc_q <= crc16_byte_step(crc_q, data_i);
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/usb_packet_builder.sv
// Builds USB packets (PID, token fields, payload, CRC5/CRC16) and writes them
// byte by byte into the host-side FIFO write port. SYNC/EOP are added later.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   cmd_val/cmd_rdy          command handshake; cmd_rdy only in IDLE
//   cmd_pid/addr/endp/len    command descriptor (SOF frame number in addr/endp)
//   pl_data/pl_val/pl_rdy    payload byte stream; pl_rdy marks consumption
//   w_data/wr_en/flag_full   FIFO write port
//   busy                     packet in progress
//   pkt_done                 one-cycle pulse after the last byte is written
module usb_packet_builder
  import usb_packet_builder_pkg::*;
#(
  parameter int unsigned MAX_DATA_BYTES = 64,
  parameter int unsigned LEN_W          = $clog2(MAX_DATA_BYTES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_val,
  output logic             cmd_rdy,
  input  logic [3:0]       cmd_pid,
  input  logic [6:0]       cmd_addr,
  input  logic [3:0]       cmd_endp,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [7:0]       pl_data,
  input  logic             pl_val,
  output logic             pl_rdy,
  output logic [7:0]       w_data,
  output logic             wr_en,
  input  logic             flag_full,
  output logic             busy,
  output logic             pkt_done
);

  state_e           state_q, state_d;
  logic [3:0]       pid_q;
  logic [6:0]       addr_q;
  logic [3:0]       endp_q;
  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] len_clamped;
  logic             pkt_done_q;
  logic             cmd_acc;
  logic [15:0]      crc16;
  logic [4:0]       crc5;

  assign cmd_acc     = cmd_val && cmd_rdy;
  assign len_clamped = (cmd_len > LEN_W'(MAX_DATA_BYTES)) ? LEN_W'(MAX_DATA_BYTES) : cmd_len;
  assign crc5        = crc5_field({endp_q, addr_q});

  usb_crc16_byte u_crc16 (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (cmd_acc),
    .upd_i  (pl_rdy),
    .data_i (pl_data),
    .crc_o  (crc16)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; every non-idle transition requires a write this cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (cmd_acc) state_d = StPid;
      StPid: begin
        if (wr_en) begin
          if (is_token(pid_q)) begin
            state_d = StTok1;
          end else if (is_data(pid_q)) begin
            state_d = (cnt_q != '0) ? StData : StCrcLo;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StTok1:  if (wr_en) state_d = StTok2;
      StTok2:  if (wr_en) state_d = StIdle;
      StData:  if (wr_en && (cnt_q == LEN_W'(1))) state_d = StCrcLo;
      StCrcLo: if (wr_en) state_d = StCrcHi;
      StCrcHi: if (wr_en) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs.
  always_comb begin
    busy    = (state_q != StIdle);
    // Held low while rst is asserted so every output reads 0 during reset.
    cmd_rdy = (state_q == StIdle) && !rst;
    wr_en   = busy && !flag_full && ((state_q != StData) || pl_val);
    pl_rdy  = (state_q == StData) && wr_en;
    w_data  = 8'h00;
    unique case (state_q)
      StIdle:  w_data = 8'h00;
      StPid:   w_data = {~pid_q, pid_q};
      StTok1:  w_data = {endp_q[0], addr_q};
      StTok2:  w_data = {crc5, endp_q[3:1]};
      StData:  w_data = pl_data;
      StCrcLo: w_data = ~rev8(crc16[15:8]);
      StCrcHi: w_data = ~rev8(crc16[7:0]);
      default: w_data = 8'h00;
    endcase
  end

  // Latched command and remaining-payload counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pid_q  <= '0;
      addr_q <= '0;
      endp_q <= '0;
      cnt_q  <= '0;
    end else if (cmd_acc) begin
      pid_q  <= cmd_pid;
      addr_q <= cmd_addr;
      endp_q <= cmd_endp;
      cnt_q  <= len_clamped;
    end else if (pl_rdy) begin
      cnt_q  <= cnt_q - LEN_W'(1);
    end
  end

  // A write that returns the FSM to IDLE is the final byte of the packet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_done_q <= 1'b0;
    end else begin
      pkt_done_q <= wr_en && (state_d == StIdle);
    end
  end

  assign pkt_done = pkt_done_q;

endmodule

// File: tb/tb_usb_packet_builder.sv
module tb_usb_packet_builder;

  localparam int MaxBytes = 64;

  typedef struct packed {
    logic [7:0] b;
    logic       pay;
    logic       last;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_val = 1'b0;
  logic       cmd_rdy;
  logic [3:0] cmd_pid = '0;
  logic [6:0] cmd_addr = '0;
  logic [3:0] cmd_endp = '0;
  logic [6:0] cmd_len = '0;
  logic [7:0] pl_data = '0;
  logic       pl_val = 1'b0;
  logic       pl_rdy;
  logic [7:0] w_data;
  logic       wr_en;
  logic       flag_full = 1'b0;
  logic       busy;
  logic       pkt_done;

  int   vecs = 0;
  int   errs = 0;
  int   cyc = 0;
  int   acc_cyc = -1;
  int   first_wr = -1;
  int   last_wr = -1;
  int   done_cyc = -1;
  int   pl_idx = 0;
  bit   active = 0;
  bit   done_pend = 0;
  exp_t exp_q[$];
  logic [7:0] act_q[$];
  logic [7:0] payload [128];

  usb_packet_builder dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_val   (cmd_val),
    .cmd_rdy   (cmd_rdy),
    .cmd_pid   (cmd_pid),
    .cmd_addr  (cmd_addr),
    .cmd_endp  (cmd_endp),
    .cmd_len   (cmd_len),
    .pl_data   (pl_data),
    .pl_val    (pl_val),
    .pl_rdy    (pl_rdy),
    .w_data    (w_data),
    .wr_en     (wr_en),
    .flag_full (flag_full),
    .busy      (busy),
    .pkt_done  (pkt_done)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %b want %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %02h want %02h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model: packet as a byte list ----------------
  function automatic logic [4:0] ref_crc5(input logic [6:0] addr, input logic [3:0] endp);
    bit         bq[$];
    logic [4:0] c = 5'h1F;
    logic [10:0] fld = {endp, addr};
    for (int i = 0; i < 11; i++) bq.push_back(fld[i]);
    foreach (bq[i]) begin
      if (c[4] ^ bq[i]) c = {c[3:0], 1'b0} ^ 5'h05;
      else c = {c[3:0], 1'b0};
    end
    return c;
  endfunction

  function automatic logic [15:0] ref_crc16(input int n);
    bit          bq[$];
    logic [15:0] c = 16'hFFFF;
    logic [7:0]  b;
    for (int k = 0; k < n; k++) begin
      b = payload[7'(k)];
      for (int i = 0; i < 8; i++) bq.push_back(b[i]);
    end
    foreach (bq[i]) begin
      if (c[15] ^ bq[i]) c = {c[14:0], 1'b0} ^ 16'h8005;
      else c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  task automatic build_exp(input logic [3:0] pid, input logic [6:0] addr,
                           input logic [3:0] endp, input int len);
    exp_t        e;
    bit          istok, isdat;
    int          n;
    logic [4:0]  c5;
    logic [15:0] c16;
    logic [7:0]  b;
    istok = pid inside {4'h1, 4'h9, 4'h5, 4'hD};
    isdat = pid inside {4'h3, 4'hB, 4'h7, 4'hF};
    e = '{b: {~pid, pid}, pay: 1'b0, last: !(istok || isdat)};
    exp_q.push_back(e);
    if (istok) begin
      exp_q.push_back('{b: {endp[0], addr}, pay: 1'b0, last: 1'b0});
      c5 = ref_crc5(addr, endp);
      b[2:0] = endp[3:1];
      for (int i = 0; i < 5; i++) b[3+i] = ~c5[4-i];
      exp_q.push_back('{b: b, pay: 1'b0, last: 1'b1});
    end else if (isdat) begin
      n = (len > MaxBytes) ? MaxBytes : len;
      for (int k = 0; k < n; k++) exp_q.push_back('{b: payload[7'(k)], pay: 1'b1, last: 1'b0});
      c16 = ref_crc16(n);
      for (int i = 0; i < 8; i++) b[i] = ~c16[15-i];
      exp_q.push_back('{b: b, pay: 1'b0, last: 1'b0});
      for (int i = 0; i < 8; i++) b[i] = ~c16[7-i];
      exp_q.push_back('{b: b, pay: 1'b0, last: 1'b1});
    end
  endtask

  // ---------------- compare process ----------------
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst) begin
      chk1("rst_wr_en", wr_en, 1'b0);
      chk1("rst_pl_rdy", pl_rdy, 1'b0);
      chk8("rst_w_data", w_data, 8'h00);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_pkt_done", pkt_done, 1'b0);
    end else begin
      chk1("busy", busy, active);
      chk1("cmd_rdy", cmd_rdy, !active);
      chk1("pkt_done", pkt_done, done_pend);
      if (pkt_done) done_cyc = cyc;
      done_pend = 0;
      if (wr_en) begin
        chk1("write_while_full", flag_full, 1'b0);
        if (exp_q.size() == 0) begin
          vecs++;
          errs++;
          $display("FAIL unexpected_write: got %02h want no write (cycle %0d)", w_data, cyc);
        end else begin
          e = exp_q.pop_front();
          chk8("w_data", w_data, e.b);
          chk1("pl_rdy", pl_rdy, e.pay);
          if (e.last) begin
            done_pend = 1;
            active = 0;
          end
        end
        if (act_q.size() == 0) first_wr = cyc;
        last_wr = cyc;
        act_q.push_back(w_data);
      end else begin
        chk1("pl_rdy_no_write", pl_rdy, 1'b0);
      end
      if (pl_rdy) pl_idx++;
      if (cmd_val && cmd_rdy) begin
        active = 1;
        acc_cyc = cyc;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic start_cmd(input logic [3:0] pid, input logic [6:0] addr,
                           input logic [3:0] endp, input int len);
    int t = 0;
    build_exp(pid, addr, endp, len);
    act_q.delete();
    pl_idx = 0;
    while (!cmd_rdy && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk1("cmd_rdy_wait", cmd_rdy, 1'b1);
    cmd_val  = 1'b1;
    cmd_pid  = pid;
    cmd_addr = addr;
    cmd_endp = endp;
    cmd_len  = 7'(len);
    @(posedge clk);
    #1;
    cmd_val = 1'b0;
  endtask

  // Stall windows are in cycles after the accept cycle (k=1 is the first
  // possible PID-write cycle).
  task automatic run_pkt(input logic [3:0] pid, input logic [6:0] addr, input logic [3:0] endp,
                         input int len, input int pv_s, input int pv_n,
                         input int f_s, input int f_n);
    int k = 1;
    start_cmd(pid, addr, endp, len);
    while ((exp_q.size() != 0 || done_pend) && k < 400) begin
      pl_val    = !(k >= pv_s && k < pv_s + pv_n);
      flag_full = (k >= f_s && k < f_s + f_n);
      pl_data   = payload[7'(pl_idx)];
      @(posedge clk);
      #1;
      k++;
    end
    pl_val    = 1'b0;
    flag_full = 1'b0;
    chki("packet_completes", exp_q.size(), 0);
  endtask

  task automatic chk_timing(input string name, input int n);
    chki({name, "_first_wr"}, first_wr, acc_cyc + 1);
    chki({name, "_last_wr"}, last_wr, acc_cyc + n);
    chki({name, "_done"}, done_cyc, acc_cyc + n + 1);
  endtask

  initial begin
    int t;
    for (int i = 0; i < 128; i++) payload[i] = 8'(i);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk1("cmd_rdy_after_reset", cmd_rdy, 1'b1);
    chk1("busy_after_reset", busy, 1'b0);

    // SETUP addr 0 endp 0
    run_pkt(4'hD, 7'h00, 4'h0, 0, 0, 0, 0, 0);
    chki("setup_len", act_q.size(), 3);
    chk8("setup_b0", act_q[0], 8'h2D);
    chk8("setup_b1", act_q[1], 8'h00);
    chk8("setup_b2", act_q[2], 8'h10);
    chk_timing("setup", 3);

    // IN addr 0 endp 0
    run_pkt(4'h9, 7'h00, 4'h0, 0, 0, 0, 0, 0);
    chk8("in_b0", act_q[0], 8'h69);
    chk8("in_b2", act_q[2], 8'h10);
    chk_timing("in", 3);

    // ACK: PID only
    run_pkt(4'h2, 7'h11, 4'h3, 5, 0, 0, 0, 0);
    chki("ack_len", act_q.size(), 1);
    chk8("ack_b0", act_q[0], 8'hD2);
    chk_timing("ack", 1);

    // DATA0, zero length
    run_pkt(4'h3, 7'h00, 4'h0, 0, 0, 0, 0, 0);
    chki("data0_len", act_q.size(), 3);
    chk8("data0_b0", act_q[0], 8'hC3);
    chk8("data0_b1", act_q[1], 8'h00);
    chk8("data0_b2", act_q[2], 8'h00);

    // OUT with non-zero address/endpoint, FIFO full on the TOK1 cycle
    run_pkt(4'h1, 7'h3A, 4'hA, 0, 0, 0, 2, 2);
    chk8("out_b0", act_q[0], 8'hE1);
    chk8("out_b1", act_q[1], 8'h3A);

    // DATA1, 4 bytes, pl_val low 2 cycles then FIFO full 3 cycles mid-payload
    run_pkt(4'hB, 7'h00, 4'h0, 4, 3, 2, 5, 3);
    chki("data1_len", act_q.size(), 7);
    chk8("data1_b0", act_q[0], 8'h4B);
    chk8("data1_p0", act_q[1], 8'h00);
    chk8("data1_p1", act_q[2], 8'h01);
    chk8("data1_p2", act_q[3], 8'h02);
    chk8("data1_p3", act_q[4], 8'h03);
    chki("data1_pl_rdy_count", pl_idx, 4);

    // Oversized length is clamped
    for (int i = 0; i < 128; i++) payload[i] = 8'(i * 7 + 3);
    run_pkt(4'h7, 7'h00, 4'h0, 70, 10, 1, 30, 2);
    chki("clamp_pl_rdy_count", pl_idx, 64);
    chki("clamp_len", act_q.size(), 67);

    // Reset during payload byte 2
    start_cmd(4'h3, 7'h00, 4'h0, 8);
    pl_val = 1'b1;
    t = 0;
    while (pl_idx < 2 && t < 50) begin
      pl_data = payload[7'(pl_idx)];
      @(posedge clk);
      #1;
      t++;
    end
    chki("reached_byte2", pl_idx, 2);
    pl_data = payload[2];
    rst = 1'b1;
    #1;
    chk1("mid_rst_wr_en", wr_en, 1'b0);
    chk1("mid_rst_pl_rdy", pl_rdy, 1'b0);
    chk8("mid_rst_w_data", w_data, 8'h00);
    chk1("mid_rst_busy", busy, 1'b0);
    chk1("mid_rst_cmd_rdy", cmd_rdy, 1'b0);
    exp_q.delete();
    active = 0;
    done_pend = 0;
    pl_val = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk1("cmd_rdy_after_mid_rst", cmd_rdy, 1'b1);
    run_pkt(4'hD, 7'h15, 4'hE, 0, 0, 0, 0, 0);
    chki("post_rst_setup_len", act_q.size(), 3);
    chk8("post_rst_setup_b0", act_q[0], 8'h2D);
    chk8("post_rst_setup_b1", act_q[1], 8'h15);
    chk_timing("post_rst_setup", 3);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
